segre_sb_drain_ctrl: RTL and testbench

SEGRE_SB_DRAIN_CTRL -- requirements
Module: segre_sb_drain_ctrl

---
 rtl/segre_pkg.sv | 15 +
 rtl/segre_sb_drain_ctrl.sv | 111 +++++++++++
 tb/tb_segre_sb_drain_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/segre_pkg.sv
// Shared types and default sizing for the store-buffer drain controller.
package segre_pkg;

  localparam int SB_NUM_ELEMS    = 2;
  localparam int SB_STARVE_LIMIT = 8;

  typedef enum logic [2:0] {
    SB_NORMAL     = 3'd0,
    SB_STARVE     = 3'd1,
    SB_FORCE      = 3'd2,
    SB_FENCE      = 3'd3,
    SB_FENCE_DONE = 3'd4
  } sb_ctrl_state_e;

endpackage

// File: rtl/segre_sb_drain_ctrl.sv
// Arbitrates the data-cache port between loads and store-buffer drains, tracks
// store-buffer occupancy, and sequences starvation relief, forced drains and fences.
module segre_sb_drain_ctrl #(
  parameter int SB_NUM_ELEMS    = segre_pkg::SB_NUM_ELEMS,
  parameter int SB_STARVE_LIMIT = segre_pkg::SB_STARVE_LIMIT
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              load_req_i,
  input  logic                              store_req_i,
  input  logic                              sb_hit_i,
  input  logic                              sb_trouble_i,
  input  logic                              sb_flush_valid_i,
  input  logic                              fence_req_i,
  input  logic                              cache_ready_i,
  output logic                              flush_chance_o,
  output logic                              load_grant_o,
  output logic                              pipe_stall_o,
  output logic                              fence_done_o,
  output logic [$clog2(SB_NUM_ELEMS+1)-1:0] occupancy_o,
  output logic                              err_o
);
  import segre_pkg::*;

  localparam int OCC_W = $clog2(SB_NUM_ELEMS + 1);
  localparam int CNT_W = $clog2(SB_STARVE_LIMIT + 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(SB_NUM_ELEMS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SB_STARVE_LIMIT - 1);

  sb_ctrl_state_e   state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic occ_inc, occ_dec, occ_nz;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SB_NORMAL;
      occ_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Occupancy: a simultaneous allocate and drain cancel out.
  always_comb begin
    occ_inc = store_req_i & ~sb_hit_i & (occ_q < OCC_MAX);
    occ_dec = sb_flush_valid_i;
    occ_nz  = (occ_q != '0);
    occ_d   = occ_q;
    err_d   = err_q;
    if (occ_inc && !occ_dec) begin
      occ_d = occ_q + 1'b1;
    end else if (occ_dec && !occ_inc) begin
      if (occ_nz) occ_d = occ_q - 1'b1;
      else        err_d = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    flush_chance_o = 1'b0;
    load_grant_o   = 1'b0;
    pipe_stall_o   = 1'b0;
    fence_done_o   = 1'b0;
    unique case (state_q)
      SB_NORMAL: begin
        load_grant_o   = load_req_i & cache_ready_i;
        flush_chance_o = cache_ready_i & ~load_req_i & occ_nz;
        pipe_stall_o   = store_req_i & ~sb_hit_i & (occ_q == OCC_MAX);
        if (occ_nz && !sb_flush_valid_i) cnt_d = cnt_q + 1'b1;
        if (sb_trouble_i && (store_req_i || load_req_i)) state_d = SB_FORCE;
        else if (fence_req_i)                            state_d = SB_FENCE;
        else if ((cnt_q == CNT_LAST) && occ_nz)          state_d = SB_STARVE;
      end
      SB_STARVE: begin
        flush_chance_o = cache_ready_i;
        pipe_stall_o   = load_req_i | store_req_i;
        if (sb_flush_valid_i) state_d = SB_NORMAL;
      end
      SB_FORCE: begin
        flush_chance_o = cache_ready_i & occ_nz;
        pipe_stall_o   = 1'b1;
        if (!occ_nz) state_d = SB_NORMAL;
      end
      SB_FENCE: begin
        flush_chance_o = cache_ready_i & occ_nz;
        pipe_stall_o   = 1'b1;
        if (!occ_nz) state_d = SB_FENCE_DONE;
      end
      SB_FENCE_DONE: begin
        fence_done_o = 1'b1;
        state_d      = SB_NORMAL;
      end
      default: state_d = SB_NORMAL;
    endcase
    // The starvation count only survives while staying in NORMAL.
    if (state_d != SB_NORMAL) cnt_d = '0;
  end

  assign occupancy_o = occ_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_segre_sb_drain_ctrl.sv
// Directed bench for segre_sb_drain_ctrl: vector table plus multi-cycle sequences.
module tb_segre_sb_drain_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       load_req_i, store_req_i, sb_hit_i, sb_trouble_i;
  logic       sb_flush_valid_i, fence_req_i, cache_ready_i;
  logic       flush_chance_o, load_grant_o, pipe_stall_o, fence_done_o, err_o;
  logic [1:0] occupancy_o;

  int errors = 0;
  int checks = 0;

  segre_sb_drain_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .load_req_i       (load_req_i),
    .store_req_i      (store_req_i),
    .sb_hit_i         (sb_hit_i),
    .sb_trouble_i     (sb_trouble_i),
    .sb_flush_valid_i (sb_flush_valid_i),
    .fence_req_i      (fence_req_i),
    .cache_ready_i    (cache_ready_i),
    .flush_chance_o   (flush_chance_o),
    .load_grant_o     (load_grant_o),
    .pipe_stall_o     (pipe_stall_o),
    .fence_done_o     (fence_done_o),
    .occupancy_o      (occupancy_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       ld, st, hit, tr, fl, fe, rdy;
    logic       fc, lg, stl, dn;
    logic [1:0] occ;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ld, logic st, logic hit, logic tr, logic fl,
                              logic fe, logic rdy, logic fc, logic lg, logic stl,
                              logic dn, logic [1:0] occ, logic err);
    vec_t v;
    v.ld = ld; v.st = st; v.hit = hit; v.tr = tr; v.fl = fl; v.fe = fe; v.rdy = rdy;
    v.fc = fc; v.lg = lg; v.stl = stl; v.dn = dn; v.occ = occ; v.err = err;
    return v;
  endfunction

  task automatic chk(string nm, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic outs(string nm, logic fc, logic lg, logic stl, logic dn,
                      logic [1:0] occ, logic err);
    chk({nm, ".flush_chance"}, {1'b0, flush_chance_o}, {1'b0, fc});
    chk({nm, ".load_grant"},   {1'b0, load_grant_o},   {1'b0, lg});
    chk({nm, ".pipe_stall"},   {1'b0, pipe_stall_o},   {1'b0, stl});
    chk({nm, ".fence_done"},   {1'b0, fence_done_o},   {1'b0, dn});
    chk({nm, ".occupancy"},    occupancy_o,            occ);
    chk({nm, ".err"},          {1'b0, err_o},          {1'b0, err});
    checks++;
    if (flush_chance_o && load_grant_o) begin
      errors++;
      $display("FAIL %s.exclusive: got flush_chance=1 load_grant=1 expected not both", nm);
    end
  endtask

  task automatic drv(logic ld, logic st, logic hit, logic tr, logic fl, logic fe, logic rdy);
    load_req_i = ld; store_req_i = st; sb_hit_i = hit; sb_trouble_i = tr;
    sb_flush_valid_i = fl; fence_req_i = fe; cache_ready_i = rdy;
  endtask

  // Inputs are driven just after a rising edge; outputs sampled on the falling edge.
  task automatic cyc(string nm, logic fc, logic lg, logic stl, logic dn,
                     logic [1:0] occ, logic err);
    @(negedge clk_i);
    outs(nm, fc, lg, stl, dn, occ, err);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(string nm);
    rst_i = 1'b1;
    drv(1, 0, 0, 0, 0, 0, 1);
    #2;
    outs(nm, 0, 1, 0, 0, 2'd0, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;

    //        ld st ht tr fl fe rd  fc lg st dn occ err
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 2'd2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 2'd2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 2'd0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1,  1, 0, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  1, 0, 1, 0, 2'd2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 2'd2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 2'd2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 2'd1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2'd0, 1));

    do_reset("rst0");
    foreach (tbl[i]) begin
      drv(tbl[i].ld, tbl[i].st, tbl[i].hit, tbl[i].tr, tbl[i].fl, tbl[i].fe, tbl[i].rdy);
      cyc($sformatf("vec%0d", i), tbl[i].fc, tbl[i].lg, tbl[i].stl, tbl[i].dn,
          tbl[i].occ, tbl[i].err);
    end

    // Starvation: one buffered store while loads hog the port.
    do_reset("rst_starve");
    drv(0, 1, 0, 0, 0, 0, 1);
    cyc("starve_store", 0, 0, 0, 0, 2'd0, 0);
    drv(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      cyc($sformatf("starve_norm%0d", i), 0, 1, 0, 0, 2'd1, 0);
    cyc("starve_on", 1, 0, 1, 0, 2'd1, 0);
    cyc("starve_hold", 1, 0, 1, 0, 2'd1, 0);
    drv(1, 0, 0, 0, 1, 0, 1);
    cyc("starve_flush", 1, 0, 1, 0, 2'd1, 0);
    drv(1, 0, 0, 0, 0, 0, 1);
    cyc("starve_exit", 0, 1, 0, 0, 2'd0, 0);

    // Forced drain on store-buffer trouble with a full buffer.
    do_reset("rst_force");
    drv(0, 1, 0, 0, 0, 0, 1);
    cyc("force_st0", 0, 0, 0, 0, 2'd0, 0);
    cyc("force_st1", 1, 0, 0, 0, 2'd1, 0);
    drv(0, 1, 0, 1, 0, 0, 1);
    cyc("force_trig", 1, 0, 1, 0, 2'd2, 0);
    drv(1, 0, 0, 0, 0, 0, 1);
    cyc("force_ld", 1, 0, 1, 0, 2'd2, 0);
    drv(0, 0, 0, 0, 1, 0, 1);
    cyc("force_fl1", 1, 0, 1, 0, 2'd2, 0);
    cyc("force_fl2", 1, 0, 1, 0, 2'd1, 0);
    drv(0, 0, 0, 0, 0, 0, 1);
    cyc("force_empty", 0, 0, 1, 0, 2'd0, 0);
    drv(1, 0, 0, 0, 0, 0, 1);
    cyc("force_exit", 0, 1, 0, 0, 2'd0, 0);

    // Fence with an empty buffer, then with one entry.
    do_reset("rst_fence");
    drv(0, 0, 0, 0, 0, 1, 1);
    cyc("fen0_req", 0, 0, 0, 0, 2'd0, 0);
    cyc("fen0_fence", 0, 0, 1, 0, 2'd0, 0);
    drv(1, 0, 0, 0, 0, 1, 1);
    cyc("fen0_done", 0, 0, 0, 1, 2'd0, 0);
    drv(1, 0, 0, 0, 0, 0, 1);
    cyc("fen0_norm", 0, 1, 0, 0, 2'd0, 0);
    drv(0, 1, 0, 0, 0, 0, 1);
    cyc("fen1_store", 0, 0, 0, 0, 2'd0, 0);
    drv(0, 0, 0, 0, 0, 1, 1);
    cyc("fen1_req", 1, 0, 0, 0, 2'd1, 0);
    drv(0, 0, 0, 0, 1, 1, 1);
    cyc("fen1_drain", 1, 0, 1, 0, 2'd1, 0);
    drv(0, 0, 0, 0, 0, 1, 1);
    cyc("fen1_empty", 0, 0, 1, 0, 2'd0, 0);
    cyc("fen1_done", 0, 0, 0, 1, 2'd0, 0);
    drv(0, 0, 0, 0, 0, 0, 1);
    cyc("fen1_norm", 0, 0, 0, 0, 2'd0, 0);

    // Reset while fencing a full buffer abandons the drain.
    do_reset("rst_rf");
    drv(0, 1, 0, 0, 0, 0, 1);
    cyc("rf_st0", 0, 0, 0, 0, 2'd0, 0);
    cyc("rf_st1", 1, 0, 0, 0, 2'd1, 0);
    drv(0, 0, 0, 0, 0, 1, 1);
    cyc("rf_req", 1, 0, 0, 0, 2'd2, 0);
    @(negedge clk_i);
    outs("rf_fence", 1, 0, 1, 0, 2'd2, 0);
    #1;
    rst_i = 1'b1;
    #1;
    outs("rf_rst", 0, 0, 0, 0, 2'd0, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("rf_after%0d", i), 0, 0, 0, 0, 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
